// File: rtl/mem_arbiter_if.sv
// Host/memory bus bundle for mem_arbiter: two requesters on one side, a single
// downstream memory port on the other.
interface mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512
);
    logic                  buffer_addr_valid;
    logic [1:0]            req_valid;
    logic [1:0]            req_write;
    logic [2*ADDR_W-1:0]   req_addr;
    logic [2*DATA_W-1:0]   req_data;
    logic [1:0]            req_ready;
    logic [1:0]            rsp_valid;
    logic [DATA_W-1:0]     rsp_data;
    logic                  mem_valid;
    logic                  mem_write;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_data;
    logic                  mem_ready;
    logic                  mem_rsp_valid;
    logic [DATA_W-1:0]     mem_rsp_data;
    logic                  timeout_err;

    modport slave (
        input  buffer_addr_valid, req_valid, req_write, req_addr, req_data,
        input  mem_ready, mem_rsp_valid, mem_rsp_data,
        output req_ready, rsp_valid, rsp_data,
        output mem_valid, mem_write, mem_addr, mem_data, timeout_err
    );

    modport master (
        output buffer_addr_valid, req_valid, req_write, req_addr, req_data,
        output mem_ready, mem_rsp_valid, mem_rsp_data,
        input  req_ready, rsp_valid, rsp_data,
        input  mem_valid, mem_write, mem_addr, mem_data, timeout_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter with a single outstanding memory transaction.
// Optional response watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 512,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t              r_state;
    logic                r_last_grant;
    logic                r_owner;
    logic                r_mem_valid;
    logic                r_mem_write;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_data;

    logic                w_grant;
    logic                w_winner;
    logic                w_rsp_fire;
    logic                w_done;

    assign w_grant    = (r_state == IDLE) && bus.buffer_addr_valid && (|bus.req_valid);
    // Contention goes to whoever did not win last; a lone requester always wins.
    assign w_winner   = (&bus.req_valid) ? ~r_last_grant : bus.req_valid[1];
    assign w_rsp_fire = (r_state == WAIT) && bus.mem_rsp_valid;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]    r_wd_cnt;
    logic                r_timeout_err;
    logic                w_to_fire;

    // Counter is 0 on the first WAIT cycle, so TIMEOUT_CYC-1 marks the last allowed one.
    assign w_to_fire       = (r_state == WAIT) && !bus.mem_rsp_valid &&
                             (r_wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign w_done          = w_rsp_fire | w_to_fire;
    assign bus.timeout_err = r_timeout_err | w_to_fire;
`else
    assign w_done          = w_rsp_fire;
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.req_ready = w_grant ? (w_winner ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_valid = w_done  ? (r_owner  ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_data  = w_rsp_fire ? bus.mem_rsp_data : '0;
    assign bus.mem_valid = r_mem_valid;
    assign bus.mem_write = r_mem_write;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_data  = r_mem_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_last_grant  <= 1'b1;
            r_owner       <= 1'b0;
            r_mem_valid   <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_data    <= '0;
`ifdef ARB_TIMEOUT_EN
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner      <= w_winner;
                        r_last_grant <= w_winner;
                        r_mem_valid  <= 1'b1;
                        r_mem_write  <= w_winner ? bus.req_write[1] : bus.req_write[0];
                        r_mem_addr   <= w_winner ? bus.req_addr[2*ADDR_W-1:ADDR_W]
                                                 : bus.req_addr[ADDR_W-1:0];
                        r_mem_data   <= w_winner ? bus.req_data[2*DATA_W-1:DATA_W]
                                                 : bus.req_data[DATA_W-1:0];
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.mem_ready) begin
                        r_mem_valid <= 1'b0;
                        r_state     <= WAIT;
`ifdef ARB_TIMEOUT_EN
                        r_wd_cnt    <= '0;
`endif
                    end
                end
                WAIT: begin
`ifdef ARB_TIMEOUT_EN
                    r_wd_cnt <= r_wd_cnt + 1'b1;
                    if (w_to_fire)
                        r_timeout_err <= 1'b1;
`endif
                    if (w_done)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; inputs change and outputs are
// checked in the low clock phase, state advances on the rising edge.
module tb_mem_arbiter;
    localparam int AW = 64;
    localparam int DW = 512;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    logic [DW-1:0] a5_line;
    logic [1:0]    exp_owner;

    initial begin
        a5_line                = {64{8'hA5}};
        bus.buffer_addr_valid  = 1'b0;
        bus.req_valid          = 2'b00;
        bus.req_write          = 2'b00;
        bus.req_addr           = '0;
        bus.req_data           = '0;
        bus.mem_ready          = 1'b0;
        bus.mem_rsp_valid      = 1'b0;
        bus.mem_rsp_data       = '0;

        // Reset state
        nxt(); #1;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_mem_valid", bus.mem_valid, 0);
        chk("rst_mem_write", bus.mem_write, 0);
        chk("rst_mem_addr",  bus.mem_addr, 0);
        chk("rst_mem_data",  bus.mem_data, 0);
        chk("rst_rsp_data",  bus.rsp_data, 0);
        chk("rst_timeout",   bus.timeout_err, 0);
        rst_n = 1'b1;

        // Grants blocked until the buffer address is programmed
        bus.req_valid         = 2'b01;
        bus.req_addr[AW-1:0]  = 64'h40;
        for (int i = 0; i < 10; i++) begin
            nxt(); #1;
            chk("gate_req_ready", bus.req_ready, 0);
            chk("gate_mem_valid", bus.mem_valid, 0);
        end
        nxt(); bus.buffer_addr_valid = 1'b1; #1;
        chk("gate_open_grant", bus.req_ready, 2'b01);

        // mem_ready held low: request stays stable
        for (int i = 0; i < 5; i++) begin
            nxt(); bus.req_valid = 2'b00; #1;
            chk("hold_mem_valid", bus.mem_valid, 1);
            chk("hold_mem_addr",  bus.mem_addr, 64'h40);
            chk("hold_mem_write", bus.mem_write, 0);
            chk("hold_req_ready", bus.req_ready, 0);
        end
        nxt(); bus.mem_ready = 1'b1; #1;
        chk("hs_mem_valid", bus.mem_valid, 1);
        nxt(); bus.mem_ready = 1'b0; #1;
        chk("wait_mem_valid", bus.mem_valid, 0);
        chk("wait_rsp_valid", bus.rsp_valid, 0);
        nxt(); bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 512'h1234; #1;
        chk("cpu_rsp_valid", bus.rsp_valid, 2'b01);
        chk("cpu_rsp_data",  bus.rsp_data, 512'h1234);
        nxt(); bus.mem_rsp_valid = 1'b0; #1;
        chk("cpu_rsp_clear", bus.rsp_valid, 0);
        chk("cpu_rsp_data0", bus.rsp_data, 0);

        // Aux write
        bus.req_valid              = 2'b10;
        bus.req_write              = 2'b10;
        bus.req_addr[2*AW-1:AW]    = 64'h80;
        bus.req_data[2*DW-1:DW]    = a5_line;
        #1;
        chk("aux_grant", bus.req_ready, 2'b10);
        nxt(); bus.req_valid = 2'b00; bus.req_write = 2'b00; bus.mem_ready = 1'b1; #1;
        chk("aux_mem_valid", bus.mem_valid, 1);
        chk("aux_mem_write", bus.mem_write, 1);
        chk("aux_mem_addr",  bus.mem_addr, 64'h80);
        chk("aux_mem_data",  bus.mem_data, a5_line);
        nxt(); bus.mem_ready = 1'b0; #1;
        chk("aux_wait", bus.mem_valid, 0);
        nxt(); bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = '0; #1;
        chk("aux_rsp_valid", bus.rsp_valid, 2'b10);
        nxt(); bus.mem_rsp_valid = 1'b0; #1;
        chk("aux_rsp_clear", bus.rsp_valid, 0);

        // Round-robin under continuous contention
        bus.req_addr  = {64'h200, 64'h100};
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_owner = (k % 2 == 1) ? 2'b10 : 2'b01;
            nxt(); bus.mem_rsp_valid = 1'b0; bus.req_valid = 2'b11; #1;
            chk("rr_grant", bus.req_ready, exp_owner);
            nxt(); #1;
            chk("rr_issue_ready", bus.req_ready, 0);
            chk("rr_issue_valid", bus.mem_valid, 1);
            chk("rr_issue_addr",  bus.mem_addr, (k % 2 == 1) ? 64'h200 : 64'h100);
            nxt(); #1;
            chk("rr_wait_rsp", bus.rsp_valid, 0);
            nxt(); #1;
            chk("rr_wait_ready", bus.req_ready, 0);
            nxt(); bus.mem_rsp_valid = 1'b1; #1;
            chk("rr_rsp", bus.rsp_valid, exp_owner);
            chk("rr_rsp_no_grant", bus.req_ready, 0);
        end
        nxt(); bus.mem_rsp_valid = 1'b0; bus.req_valid = 2'b00; bus.mem_ready = 1'b0; #1;

        // Spurious response in IDLE
        nxt(); bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 512'h77; #1;
        chk("spur_rsp_valid", bus.rsp_valid, 0);
        chk("spur_rsp_data",  bus.rsp_data, 0);

        // Reset while waiting discards the transaction
        nxt(); bus.mem_rsp_valid = 1'b0; bus.req_valid = 2'b01; #1;
        chk("rstw_grant", bus.req_ready, 2'b01);
        nxt(); bus.req_valid = 2'b00; bus.mem_ready = 1'b1; #1;
        chk("rstw_issue", bus.mem_valid, 1);
        nxt(); bus.mem_ready = 1'b0; #1;
        chk("rstw_wait", bus.mem_valid, 0);
        rst_n = 1'b0; #1;
        chk("rstw_mem_valid", bus.mem_valid, 0);
        chk("rstw_mem_addr",  bus.mem_addr, 0);
        chk("rstw_mem_data",  bus.mem_data, 0);
        chk("rstw_rsp_valid", bus.rsp_valid, 0);
        chk("rstw_req_ready", bus.req_ready, 0);
        nxt(); rst_n = 1'b1; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 512'h55; #1;
        chk("rstw_late_rsp",  bus.rsp_valid, 0);
        chk("rstw_late_data", bus.rsp_data, 0);

        // Dropping buffer_addr_valid mid-transaction does not abort it
        nxt(); bus.mem_rsp_valid = 1'b0; bus.req_valid = 2'b01; #1;
        chk("bav_grant", bus.req_ready, 2'b01);
        nxt(); bus.req_valid = 2'b00; bus.buffer_addr_valid = 1'b0; #1;
        chk("bav_issue_held", bus.mem_valid, 1);
        nxt(); bus.mem_ready = 1'b1; #1;
        chk("bav_issue_hs", bus.mem_valid, 1);
        nxt(); bus.mem_ready = 1'b0; #1;
        nxt(); bus.mem_rsp_valid = 1'b1; #1;
        chk("bav_rsp", bus.rsp_valid, 2'b01);
        nxt(); bus.mem_rsp_valid = 1'b0; bus.req_valid = 2'b01; #1;
        chk("bav_blocked", bus.req_ready, 0);
        bus.buffer_addr_valid = 1'b1; #1;
        chk("bav_reopen", bus.req_ready, 2'b01);
        nxt(); bus.req_valid = 2'b00; bus.mem_ready = 1'b1; #1;
        nxt(); bus.mem_ready = 1'b0; #1;

        // Watchdog behaviour in WAIT (first WAIT cycle is the current one)
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i < 16; i++) begin
            chk("wd_pre_rsp", bus.rsp_valid, 0);
            chk("wd_pre_err", bus.timeout_err, 0);
            nxt(); #1;
        end
        chk("wd_fire_rsp",  bus.rsp_valid, 2'b01);
        chk("wd_fire_err",  bus.timeout_err, 1);
        chk("wd_fire_data", bus.rsp_data, 0);
        nxt(); #1;
        chk("wd_sticky", bus.timeout_err, 1);
        chk("wd_idle_rsp", bus.rsp_valid, 0);
        bus.req_valid = 2'b01; #1;
        chk("wd_idle_grant", bus.req_ready, 2'b01);
        nxt(); bus.req_valid = 2'b00; #1;
`else
        for (int i = 0; i < 20; i++) begin
            chk("nowd_rsp", bus.rsp_valid, 0);
            chk("nowd_err", bus.timeout_err, 0);
            nxt(); #1;
        end
        bus.mem_rsp_valid = 1'b1; #1;
        chk("nowd_late_rsp", bus.rsp_valid, 2'b01);
        nxt(); bus.mem_rsp_valid = 1'b0; #1;
        chk("nowd_err_final", bus.timeout_err, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
